// File: rtl/mac_row_ms.sv
// mac_row_ms: one row of the systolic array, col MAC tiles chained west-to-east.
// Weight-stationary mode holds one weight per tile and adds a product to the
// north psum. Output-stationary mode keeps a running accumulator per tile and
// returns it on drain. Activations and instructions advance one tile per cycle.
module mac_row_ms #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic [bw-1:0]          in_w,
   input  logic [2:0]             inst_w,
   input  logic [psum_bw*col-1:0] in_n,
   output logic [psum_bw*col-1:0] out_s,
   output logic [col-1:0]         valid
);

   // Signed bw x bw product, sign-extended to the psum width (psum_bw > 2*bw).
   function automatic logic signed [psum_bw-1:0] mul_ext(input logic signed [bw-1:0] a,
                                                         input logic signed [bw-1:0] w);
      logic signed [2*bw-1:0] p;
      p = (2*bw)'(a) * (2*bw)'(w);
      return {{(psum_bw-2*bw){p[2*bw-1]}}, p};
   endfunction

   // Accumulation wraps modulo 2^psum_bw; there is deliberately no saturation.
   function automatic logic [psum_bw-1:0] add_wrap(input logic [psum_bw-1:0] x,
                                                   input logic [psum_bw-1:0] y);
      return x + y;
   endfunction

   logic mode_q;
   logic mode_chg;

   assign mode_chg = (mode != mode_q);

   // Registered mode; a difference from the live pin marks a mode-change edge.
   always_ff @(posedge clk) begin
      if (reset) mode_q <= 1'b0;
      else       mode_q <= mode;
   end

   for (genvar c = 0; c < col; c++) begin : g_tile
      logic [bw-1:0]                a_in;
      logic [2:0]                   inst_in;
      logic [psum_bw-1:0]           n_in;
      logic signed [bw-1:0]         w_q;
      logic                         loaded;
      logic [psum_bw-1:0]           acc;
      logic [psum_bw-1:0]           out_q;
      logic                         vld_q;
      logic                         ld, ex, dr;
      logic signed [bw-1:0]         w_sel;
      logic signed [psum_bw-1:0]    prod;

      if (c == 0) begin : g_src
         assign a_in    = in_w;
         assign inst_in = inst_w;
      end else begin : g_src
         assign a_in    = g_tile[c-1].g_fwd.a_q;
         assign inst_in = g_tile[c-1].g_fwd.inst_q;
      end

      assign n_in = in_n[c*psum_bw +: psum_bw];
      assign ld   = inst_in[0];
      assign ex   = inst_in[1];
      assign dr   = inst_in[2];

      // Weight comes from the stationary register in WS, from the north bus in OS.
      always_comb begin
         w_sel = w_q;
         if (mode_q) w_sel = $signed(n_in[bw-1:0]);
         prod = mul_ext($signed(a_in), w_sel);
      end

      // Tile state: weight capture, WS psum add, OS accumulate and drain.
      always_ff @(posedge clk) begin
         if (reset) begin
            w_q    <= '0;
            loaded <= 1'b0;
            acc    <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
         end else if (mode_chg) begin
            loaded <= 1'b0;
            acc    <= '0;
            vld_q  <= 1'b0;
         end else begin
            vld_q <= 1'b0;
            if (!mode_q) begin
               if (ld && !loaded) begin
                  w_q    <= a_in;
                  loaded <= 1'b1;
               end
               if (ex && loaded) begin
                  out_q <= add_wrap(n_in, prod);
                  vld_q <= 1'b1;
               end
               if (dr) loaded <= 1'b0;
            end else begin
               if (dr) begin
                  out_q <= acc;
                  vld_q <= 1'b1;
                  acc   <= ex ? prod : '0;
               end else if (ex) begin
                  acc <= add_wrap(acc, prod);
               end
            end
         end
      end

      assign out_s[c*psum_bw +: psum_bw] = out_q;
      assign valid[c]                    = vld_q;

      if (c < col-1) begin : g_fwd
         logic [bw-1:0] a_q;
         logic [2:0]    inst_q;

         // Eastward stage; a WS load consumed here is not passed on.
         always_ff @(posedge clk) begin
            if (reset) a_q <= '0;
            else       a_q <= a_in;
            if (reset || mode_chg)  inst_q <= '0;
            else if (mode_q)        inst_q <= inst_in;
            else                    inst_q <= {inst_in[2:1], inst_in[0] & loaded};
         end
      end
   end

endmodule

// File: doc/mac_row_ms.md
Name: mac_row_ms

Overview:
Multi-mode, parametrised MAC row for the systolic array: `col` MAC tiles chained west-to-east.
- Weight-stationary (WS) mode: the same load/execute flow as the current row.
- Output-stationary (OS) mode: per-tile accumulators with an explicit drain.
- In both modes, activations and instructions enter on the west edge and advance one tile per cycle. Partial sums or drained results leave on the south edge with a per-column valid.

Parameters:
bw, 4, activation/weight width (two's complement)
psum_bw, 16, partial-sum/accumulator width (two's complement)
col, 8, number of tiles in the row

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
mode  in  1  0 = WS, 1 = OS
in_w  in  bw  west data: weight (WS load) or activation
inst_w  in  3  [0] load, [1] execute, [2] flush (WS) / drain (OS)
in_n  in  psum_bw*col  north input per column c (slice c*psum_bw +: psum_bw): psum in WS; low bw bits = weight in OS
out_s  out  psum_bw*col  south output per column, registered
valid  out  col  per-column pulse, registered, aligned with out_s

Behaviour:
- One clock, synchronous active-high reset. Reset clears, on the next edge:
  - every register;
  - out_s = 0, valid = 0;
  - all WS loaded flags = 0 and all OS accumulators = 0;
  - the inst/data pipeline = 0, mode_q = 0.
- West pipeline:
  - Tile 0 inputs are in_w/inst_w. Tile c>0 inputs are the a_q/inst_q registers of tile c-1.
  - Each tile registers its data input into a_q every cycle.
  - Each tile registers the instruction into inst_q, with masking defined below.
  - A word sampled at edge t is seen by tile c during cycle t+c. Its result appears at out_s/valid[c] after edge t+c+1.
- Arithmetic: product = signed(a) × signed(w), 2*bw bits, sign-extended to psum_bw. Sums wrap modulo 2^psum_bw, with no saturation.
- WS mode, per tile:
  - load and not loaded: w_q <= a_in, loaded <= 1. The load bit is not forwarded east. No MAC, even if execute is also set.
  - load and loaded: the load bit is forwarded east unchanged. So the k-th load word (k = 0..col-1) lands in tile k.
  - execute and loaded: out_s[c] <= in_n[c] + product(a_in, w_q), valid[c] <= 1.
  - execute and not loaded: no output; valid[c] <= 0.
  - flush: loaded <= 0 after any execute in the same cycle is performed. Flush is forwarded east.
  - More than col load words: the excess falls off the east end with no effect.
- OS mode, per tile (load bit ignored and forwarded; w = in_n[c][bw-1:0]; the caller provides column skew):
  - execute: acc <= acc + product(a_in, w).
  - drain: out_s[c] <= acc (value before this cycle's update), valid[c] <= 1. acc <= 0, or acc <= product if execute is also set.
  - Drain is forwarded east.
- valid[c] is 0 on every cycle not named above. out_s[c] holds its last value when valid[c] = 0.
- Mode change: mode is sampled every edge into mode_q. On any edge where mode != mode_q, all loaded flags, all accumulators and the inst pipeline clear; instructions sampled that edge are discarded. Mode should change only when the pipeline is idle; in-flight words are lost, not corrupted into wrong results.
- Reset mid-operation: reset has priority over all instructions. Nothing issued before or during reset produces valid afterwards.
- Implementation is self-contained: a generate loop of tiles plus the mode_q logic, roughly 150–250 lines.

Test Plan:
- WS basic (default params):
  - Stimulus: 8 load words in_w = 4'b1010 (−6), one per cycle; idle; 8 execute cycles with in_w = 5 and in_n = 16'h000A per column.
  - Required: every column produces out_s = 16'hFFEC (10 − 30 = −20). The first execute word gives valid[c] exactly once, c+1 cycles after issue. After the stream, valid = 8'hFF is seen as a diagonal wave and is never set at an incorrect time.
- WS distinct weights:
  - Stimulus: load words 0..7 carrying 1..7, −8; one execute with a = 2, in_n = 0.
  - Required: out_s[c] = 2·w_c, e.g. col 7 = 16'hFFF0. An extra 9th load word changes nothing. A flush followed by reload with 3 gives out_s = 6.
- OS accumulate/drain:
  - Stimulus: all columns w = 3; 4 executes with a = −2; then drain.
  - Required: out_s = 16'hFFE8 (−24) and valid[c] pulses at drain issue + c + 1. A second drain returns 0. Drain+execute with a = 1 returns the old acc and leaves acc = 3.
- Wrap:
  - Stimulus: WS, w = 7, a = 7, in_n = 16'h7FFF.
  - Required: out_s = 16'h8030, with no saturation.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle during the OS accumulate phase.
  - Required: the next cycle shows out_s = 0 and valid = 0. A subsequent drain returns 0.
- Mode switch:
  - Stimulus: load WS weights, toggle mode to OS and back, execute.
  - Required: valid stays 0, because the loaded flags were cleared.
